// File: rtl/tlb_inv_walker.sv
// INVTLB walker: sweeps every TLB entry through a one-cycle-latency key read port
// and clears the valid bit of each entry selected by the INVTLB op code.

package tlb_inv_walker_pkg;
  typedef struct packed {
    logic        e;
    logic        g;
    logic [9:0]  asid;
    logic [18:0] vppn;
    logic [5:0]  ps;
  } tlb_key_t;
endpackage

module tlb_inv_walker
  import tlb_inv_walker_pkg::*;
#(
  parameter int ENTRY_NUM = 32,
  localparam int IDX_W = (ENTRY_NUM > 1) ? $clog2(ENTRY_NUM) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inv_valid_i,
  output logic             inv_ready_o,
  input  logic [4:0]       inv_op_i,
  input  logic [9:0]       inv_asid_i,
  input  logic [18:0]      inv_vppn_i,
  output logic [IDX_W-1:0] key_raddr_o,
  input  tlb_key_t         key_rdata_i,
  output logic             update_o,
  output logic [IDX_W-1:0] update_idx_o,
  output tlb_key_t         update_key_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             illegal_op_o,
  output logic [1:0]       state_dbg_o
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SCAN  = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ENTRY_NUM - 1);
  localparam logic [4:0]       MAX_OP   = 5'd6;

  logic [1:0]       state_q, state_d;
  logic [IDX_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [IDX_W-1:0] cmp_idx_q, cmp_idx_d;
  logic             cmp_valid_q, cmp_valid_d;
  logic [4:0]       op_q, op_d;
  logic [9:0]       asid_q, asid_d;
  logic [18:0]      vppn_q, vppn_d;
  logic             done_q, done_d;
  logic             illegal_q, illegal_d;

  logic             accept;
  logic             va_match;
  logic             asid_match;
  logic             kill;

  // Handshake: a request transfers on a rising edge where inv_valid_i and
  // inv_ready_o are both high; the requester holds operands stable until then,
  // and the walker samples them only on that edge.
  assign accept = inv_valid_i && (state_q == S_IDLE);

  always_comb begin
    state_d   = state_q;
    rd_ptr_d  = rd_ptr_q;
    op_d      = op_q;
    asid_d    = asid_q;
    vppn_d    = vppn_q;
    done_d    = 1'b0;
    illegal_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          op_d     = inv_op_i;
          asid_d   = inv_asid_i;
          vppn_d   = inv_vppn_i;
          rd_ptr_d = '0;
          if (inv_op_i > MAX_OP) begin
            illegal_d = 1'b1;
          end else begin
            state_d = S_SCAN;
          end
        end
      end
      S_SCAN: begin
        // Pointer wraps back to 0 after the last entry, ready for the next walk.
        rd_ptr_d = rd_ptr_q + IDX_W'(1);
        if (rd_ptr_q == LAST_IDX) begin
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        state_d = S_IDLE;
        done_d  = 1'b1;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // The compare stage trails the read address by one cycle to line up with key_rdata_i.
  assign cmp_valid_d = (state_q == S_SCAN);
  assign cmp_idx_d   = rd_ptr_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      rd_ptr_q    <= '0;
      cmp_idx_q   <= '0;
      cmp_valid_q <= 1'b0;
      op_q        <= '0;
      asid_q      <= '0;
      vppn_q      <= '0;
      done_q      <= 1'b0;
      illegal_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      rd_ptr_q    <= rd_ptr_d;
      cmp_idx_q   <= cmp_idx_d;
      cmp_valid_q <= cmp_valid_d;
      op_q        <= op_d;
      asid_q      <= asid_d;
      vppn_q      <= vppn_d;
      done_q      <= done_d;
      illegal_q   <= illegal_d;
    end
  end

  // A 4MB page ignores the low ten VPPN bits.
  assign va_match   = (key_rdata_i.vppn[18:10] == vppn_q[18:10]) &&
                      ((key_rdata_i.ps == 6'd22) || (key_rdata_i.vppn[9:0] == vppn_q[9:0]));
  assign asid_match = (key_rdata_i.asid == asid_q);

  always_comb begin
    kill = 1'b0;
    case (op_q)
      5'd0, 5'd1: kill = 1'b1;
      5'd2:       kill = key_rdata_i.g;
      5'd3:       kill = !key_rdata_i.g;
      5'd4:       kill = !key_rdata_i.g && asid_match;
      5'd5:       kill = !key_rdata_i.g && asid_match && va_match;
      5'd6:       kill = (key_rdata_i.g || asid_match) && va_match;
      default:    kill = 1'b0;
    endcase
  end

  always_comb begin
    update_key_o   = key_rdata_i;
    update_key_o.e = 1'b0;
  end

  assign update_o     = cmp_valid_q && key_rdata_i.e && kill;
  assign update_idx_o = cmp_idx_q;
  assign key_raddr_o  = rd_ptr_q;
  assign inv_ready_o  = (state_q == S_IDLE);
  assign busy_o       = (state_q != S_IDLE);
  assign done_o       = done_q;
  assign illegal_op_o = illegal_q;
  assign state_dbg_o  = state_q;

endmodule
